// File: rtl/ipf_pkg.sv
// Shared definitions for the IPF LCU feeder: parameter-word layout, filter
// type encodings, legal LCU sizes and FSM state encoding.
package ipf_pkg;

  localparam int PRM_W        = 24;
  localparam int PRM_TYPE_LSB = 22;
  localparam int PRM_TYPE_W   = 2;
  localparam int PRM_BAND_LSB = 17;
  localparam int PRM_BAND_W   = 5;
  localparam int PRM_WO_LSB   = 16;
  localparam int PRM_OFF_LSB  = 0;
  localparam int PRM_OFF_W    = 16;

  localparam int LCU_IDX_W = 6;
  localparam int LCU_POS_W = 3;

  localparam int LCU_SIZE_S = 16;
  localparam int LCU_SIZE_M = 32;
  localparam int LCU_SIZE_L = 64;

  typedef enum logic [1:0] {
    IPF_OFF  = 2'd0,
    IPF_PO   = 2'd1,
    IPF_WO   = 2'd2,
    IPF_RSVD = 2'd3
  } ipf_type_e;

  // Field order matches the parameter SRAM word, MSB first.
  typedef struct packed {
    logic [PRM_TYPE_W-1:0] ipf_type;
    logic [PRM_BAND_W-1:0] band_pos;
    logic                  wo_class;
    logic [PRM_OFF_W-1:0]  offset;
  } prm_word_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRM0   = 3'd1;
  localparam logic [2:0] ST_PRM0_W = 3'd2;
  localparam logic [2:0] ST_STREAM = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  function automatic bit lcu_size_legal(input int s);
    return (s == LCU_SIZE_S) || (s == LCU_SIZE_M) || (s == LCU_SIZE_L);
  endfunction

endpackage

// File: rtl/ipf_lcu_addr_gen.sv
// LCU-major raster walk: col/row inside an LCU, lx/ly across the frame,
// with wrap flags and frame/parameter SRAM address composition.
module ipf_lcu_addr_gen
  import ipf_pkg::*;
#(
  parameter int IMG_W    = 128,
  parameter int LCU_SIZE = 64,
  parameter int N_LCU    = IMG_W / LCU_SIZE,
  parameter int AW       = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 adv,
  output logic [AW-1:0]        img_addr,
  output logic [LCU_IDX_W-1:0] lcu_idx,
  output logic [LCU_POS_W-1:0] lx,
  output logic [LCU_POS_W-1:0] ly,
  output logic                 lcu_first_px,
  output logic                 lcu_last,
  output logic                 frame_last_px
);

  localparam int LW = $clog2(LCU_SIZE);
  localparam int PW = AW / 2;
  localparam logic [LW-1:0]        C_MAX = LW'(LCU_SIZE - 1);
  localparam logic [LCU_POS_W-1:0] N_MAX = LCU_POS_W'(N_LCU - 1);

  logic [LW-1:0] col;
  logic [LW-1:0] row;
  logic          col_wrap;
  logic          row_wrap;
  logic          lx_wrap;
  logic [PW-1:0] gx;
  logic [PW-1:0] gy;

  assign col_wrap = (col == C_MAX);
  assign row_wrap = col_wrap && (row == C_MAX);
  assign lx_wrap  = row_wrap && (lx == N_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
      lx  <= '0;
      ly  <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
      lx  <= '0;
      ly  <= '0;
    end else if (adv) begin
      col <= col_wrap ? '0 : col + 1'b1;
      if (col_wrap) row <= (row == C_MAX) ? '0 : row + 1'b1;
      if (row_wrap) lx  <= (lx == N_MAX) ? '0 : lx + 1'b1;
      if (lx_wrap)  ly  <= (ly == N_MAX) ? '0 : ly + 1'b1;
    end
  end

  assign gx       = PW'(lx) * PW'(LCU_SIZE) + PW'(col);
  assign gy       = PW'(ly) * PW'(LCU_SIZE) + PW'(row);
  assign img_addr = {gy, gx};
  assign lcu_idx  = LCU_IDX_W'(ly) * LCU_IDX_W'(N_LCU) + LCU_IDX_W'(lx);

  assign lcu_first_px  = (col == '0) && (row == '0);
  assign lcu_last      = (lx == N_MAX) && (ly == N_MAX);
  assign frame_last_px = lx_wrap && (ly == N_MAX);

endmodule

// File: rtl/ipf_lcu_feeder.sv
// IPF upstream feeder: gapless LCU-major pixel stream with per-LCU parameters.
// Optional IPF_FEEDER_PARAM_CHECK_EN adds a sticky prm_err output and sanitises ipf_type.
module ipf_lcu_feeder
  import ipf_pkg::*;
#(
  parameter int IMG_W    = 128,
  parameter int LCU_SIZE = 64,
  parameter int N_LCU    = IMG_W / LCU_SIZE,
  parameter int AW       = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 img_rd,
  output logic [AW-1:0]        img_addr,
  input  logic [7:0]           img_q,
  output logic                 prm_rd,
  output logic [LCU_IDX_W-1:0] prm_addr,
  input  prm_word_t            prm_q,
  output logic                 in_en,
  output logic [7:0]           din,
  output logic [1:0]           ipf_type,
  output logic [4:0]           ipf_band_pos,
  output logic                 ipf_wo_class,
  output logic [15:0]          ipf_offset,
  output logic [2:0]           lcu_x,
  output logic [2:0]           lcu_y,
  output logic                 busy,
`ifdef IPF_FEEDER_PARAM_CHECK_EN
  output logic                 prm_err,
`endif
  output logic                 done
);

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic                 start_ok;
  logic                 adv;
  logic                 prefetch;
  logic                 first_px;
  logic                 lcu_last;
  logic                 last_px;
  logic [LCU_IDX_W-1:0] lcu_idx;
  logic [LCU_POS_W-1:0] lx;
  logic [LCU_POS_W-1:0] ly;

  logic                 vld_p0;
  logic                 first_p0;
  logic [LCU_POS_W-1:0] lx_p0;
  logic [LCU_POS_W-1:0] ly_p0;
  logic                 prm_vld_p0;
  prm_word_t            shadow;
  logic                 apply;
  logic [1:0]           type_out;

  ipf_lcu_addr_gen #(
    .IMG_W    (IMG_W),
    .LCU_SIZE (LCU_SIZE),
    .N_LCU    (N_LCU),
    .AW       (AW)
  ) u_addr_gen (
    .clk           (clk),
    .reset         (reset),
    .clr           (start_ok),
    .adv           (adv),
    .img_addr      (img_addr),
    .lcu_idx       (lcu_idx),
    .lx            (lx),
    .ly            (ly),
    .lcu_first_px  (first_px),
    .lcu_last      (lcu_last),
    .frame_last_px (last_px)
  );

  assign start_ok = (state == ST_IDLE) && start;
  assign adv      = (state == ST_STREAM);
  assign prefetch = adv && first_px && !lcu_last;
  assign img_rd   = adv;
  assign prm_rd   = (state == ST_PRM0) || prefetch;
  assign prm_addr = prefetch ? lcu_idx + LCU_IDX_W'(1) : '0;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_PRM0;
      ST_PRM0:   state_nxt = ST_PRM0_W;
      ST_PRM0_W: state_nxt = ST_STREAM;
      ST_STREAM: if (last_px) state_nxt = ST_DRAIN;
      // Leave once the final read has moved out of stage p0.
      ST_DRAIN:  if (!vld_p0) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Stage p0: SRAM data returning, read tags delayed to match
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0     <= 1'b0;
      first_p0   <= 1'b0;
      lx_p0      <= '0;
      ly_p0      <= '0;
      prm_vld_p0 <= 1'b0;
      shadow     <= '0;
    end else begin
      vld_p0     <= img_rd;
      first_p0   <= adv && first_px;
      lx_p0      <= lx;
      ly_p0      <= ly;
      prm_vld_p0 <= prm_rd;
      if (prm_vld_p0) shadow <= prm_q;
    end
  end

  assign apply = vld_p0 && first_p0;

`ifdef IPF_FEEDER_PARAM_CHECK_EN
  logic bad_prm;

  assign type_out = (shadow.ipf_type == IPF_RSVD) ? IPF_OFF : shadow.ipf_type;
  assign bad_prm  = (shadow.ipf_type == IPF_RSVD) ||
                    (shadow.band_pos == 5'd0) || (shadow.band_pos == 5'd31);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 prm_err <= 1'b0;
    else if (start_ok)         prm_err <= 1'b0;
    else if (apply && bad_prm) prm_err <= 1'b1;
  end
`else
  assign type_out = shadow.ipf_type;
`endif

  // Stage p1: IPF-facing registers; shadow is read here before the
  // concurrent prefetch capture overwrites it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_en        <= 1'b0;
      din          <= '0;
      ipf_type     <= '0;
      ipf_band_pos <= '0;
      ipf_wo_class <= 1'b0;
      ipf_offset   <= '0;
      lcu_x        <= '0;
      lcu_y        <= '0;
    end else begin
      in_en <= vld_p0;
      if (vld_p0) din <= img_q;
      if (apply) begin
        ipf_type     <= type_out;
        ipf_band_pos <= shadow.band_pos;
        ipf_wo_class <= shadow.wo_class;
        ipf_offset   <= shadow.offset;
        lcu_x        <= lx_p0;
        lcu_y        <= ly_p0;
      end
    end
  end

endmodule
